// File: rtl/acc_stack.sv
// acc_stack: N-source mux into a live accumulator backed by a DEPTH-entry LIFO save stack.
// Define ACC_ADD_EN to add the add_ctrl port (LOAD/PUSH accumulate acc+sel instead of load).
module acc_stack #(
  parameter int WIDTH = 8,
  parameter int NSRC  = 4,
  parameter int DEPTH = 4
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic [NSRC*WIDTH-1:0]      data_in,
  input  logic [$clog2(NSRC)-1:0]    data_ctrl,
  input  logic [1:0]                 op,
  input  logic                       accwrite_ctrl,
`ifdef ACC_ADD_EN
  input  logic                       add_ctrl,
`endif
  output logic [WIDTH-1:0]           acc_out,
  output logic [$clog2(DEPTH+1)-1:0] depth_out,
  output logic                       full,
  output logic                       empty,
  output logic                       err
);
  localparam int DW = $clog2(DEPTH + 1);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  logic [WIDTH-1:0] stack [DEPTH];
  logic [WIDTH-1:0] sel, nv;
  logic [DW-1:0] dm1;
  logic do_load, do_push, do_pop;
  always_comb begin
    sel = 32'(data_ctrl) < NSRC ? data_in[32'(data_ctrl)*WIDTH +: WIDTH] : data_in[WIDTH-1:0];
`ifdef ACC_ADD_EN
    nv = add_ctrl ? acc_out + sel : sel;
`else
    nv = sel;
`endif
    dm1 = depth_out - 1'b1;
    do_load = accwrite_ctrl && op == 2'b01;
    do_push = accwrite_ctrl && op == 2'b10;
    do_pop = accwrite_ctrl && op == 2'b11;
  end
  assign full = depth_out == DW'(DEPTH);
  assign empty = depth_out == '0;
  always_ff @(posedge CLK) begin
    if (RST) begin
      acc_out <= '0;
      depth_out <= '0;
      err <= 1'b0;
    end else begin
      if (do_load) acc_out <= nv;
      if (do_push && full) err <= 1'b1;
      if (do_push && !full) begin
        acc_out <= nv;
        depth_out <= depth_out + 1'b1;
      end
      if (do_pop && empty) err <= 1'b1;
      if (do_pop && !empty) begin
        acc_out <= stack[dm1[AW-1:0]];
        depth_out <= dm1;
      end
    end
  end
  // Entries above depth are never read, so the stack array needs no reset.
  always_ff @(posedge CLK) begin
    if (!RST && do_push && !full) stack[depth_out[AW-1:0]] <= acc_out;
  end
endmodule

// File: tb/tb_acc_stack.sv
// tb_acc_stack: directed vectors, expected state queued per cycle and checked by a monitor.
module tb_acc_stack;
  localparam logic [1:0] HOLD = 2'b00, LOAD = 2'b01, PUSH = 2'b10, POP = 2'b11;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic [31:0] data_in = '0;
  logic [1:0] data_ctrl = '0;
  logic [1:0] op = HOLD;
  logic accwrite_ctrl = 1'b0;
  logic add = 1'b0;
  logic [7:0] acc_out;
  logic [2:0] depth_out;
  logic full, empty, err;
  acc_stack #(.WIDTH(8), .NSRC(4), .DEPTH(4)) dut (
    .CLK(CLK),
    .RST(RST),
    .data_in(data_in),
    .data_ctrl(data_ctrl),
    .op(op),
    .accwrite_ctrl(accwrite_ctrl),
`ifdef ACC_ADD_EN
    .add_ctrl(add),
`endif
    .acc_out(acc_out),
    .depth_out(depth_out),
    .full(full),
    .empty(empty),
    .err(err)
  );
  always #5 CLK = ~CLK;
  typedef struct {
    string      name;
    logic [7:0] acc;
    logic [2:0] depth;
    logic       err;
  } exp_t;
  exp_t q[$];
  int checks = 0;
  int errors = 0;
  task automatic chk(string n, string f, logic [7:0] got, logic [7:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s %s: got %h expected %h", n, f, got, want);
    end
  endtask
  always @(posedge CLK) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk(e.name, "acc_out", acc_out, e.acc);
      chk(e.name, "depth_out", 8'(depth_out), 8'(e.depth));
      chk(e.name, "full", 8'(full), 8'(e.depth == 3'd4));
      chk(e.name, "empty", 8'(empty), 8'(e.depth == 3'd0));
      chk(e.name, "err", 8'(err), 8'(e.err));
    end
  end
  task automatic step(string n, logic r, logic a, logic [1:0] o, logic [1:0] c,
                      logic [31:0] d, logic ad, logic [7:0] ea, logic [2:0] ed, logic ee);
    @(negedge CLK);
    RST = r;
    accwrite_ctrl = a;
    op = o;
    data_ctrl = c;
    data_in = d;
    add = ad;
    q.push_back('{n, ea, ed, ee});
  endtask
  initial begin
    step("reset_with_load", 1, 1, LOAD, 2, 32'h0077_0000, 0, 8'h00, 0, 0);
    step("load_src2",       0, 1, LOAD, 2, 32'h005A_0000, 0, 8'h5A, 0, 0);
    step("awc_low_hold",    0, 0, LOAD, 2, 32'h00FF_0000, 0, 8'h5A, 0, 0);
    step("op_hold",         0, 1, HOLD, 1, 32'h0033_4400, 0, 8'h5A, 0, 0);
    step("load_src1",       0, 1, LOAD, 1, 32'hDD_CC_BB_AA, 0, 8'hBB, 0, 0);
    step("load_11",         0, 1, LOAD, 0, 32'hDD_CC_BB_11, 0, 8'h11, 0, 0);
    step("push_22",         0, 1, PUSH, 0, 32'h0000_0022, 0, 8'h22, 1, 0);
    step("push_33",         0, 1, PUSH, 0, 32'h0000_0033, 0, 8'h33, 2, 0);
    step("push_44",         0, 1, PUSH, 0, 32'h0000_0044, 0, 8'h44, 3, 0);
    step("push_55_full",    0, 1, PUSH, 0, 32'h0000_0055, 0, 8'h55, 4, 0);
    step("push_on_full",    0, 1, PUSH, 0, 32'h0000_0066, 0, 8'h55, 4, 1);
    step("awc_low_push",    0, 0, PUSH, 0, 32'h0000_0077, 0, 8'h55, 4, 1);
    step("pop_44",          0, 1, POP,  3, 32'h9900_0000, 0, 8'h44, 3, 1);
    step("pop_33",          0, 1, POP,  0, 32'h0000_0000, 0, 8'h33, 2, 1);
    step("pop_22",          0, 1, POP,  0, 32'h0000_0000, 0, 8'h22, 1, 1);
    step("pop_11_empty",    0, 1, POP,  0, 32'h0000_0000, 0, 8'h11, 0, 1);
    step("pop_on_empty",    0, 1, POP,  0, 32'h0000_0000, 0, 8'h11, 0, 1);
    step("load_src3",       0, 1, LOAD, 3, 32'hA5_01_02_03, 0, 8'hA5, 0, 1);
    step("push_p1",         0, 1, PUSH, 1, 32'h0000_0100, 0, 8'h01, 1, 1);
    step("push_p2",         0, 1, PUSH, 1, 32'h0000_0200, 0, 8'h02, 2, 1);
    step("push_p3",         0, 1, PUSH, 1, 32'h0000_0300, 0, 8'h03, 3, 1);
    step("push_p4",         0, 1, PUSH, 1, 32'h0000_0400, 0, 8'h04, 4, 1);
    step("pop_p3",          0, 1, POP,  1, 32'h0000_0000, 0, 8'h03, 3, 1);
    step("push_p9",         0, 1, PUSH, 1, 32'h0000_0900, 0, 8'h09, 4, 1);
    step("rst_on_full_push",1, 1, PUSH, 1, 32'h0000_0800, 0, 8'h00, 0, 0);
    step("pop_empty_err",   0, 1, POP,  0, 32'h0000_0000, 0, 8'h00, 0, 1);
    step("rst_clears_err",  1, 0, HOLD, 0, 32'h0000_0000, 0, 8'h00, 0, 0);
    step("push_then_pop_a", 0, 1, PUSH, 2, 32'h00C3_0000, 0, 8'hC3, 1, 0);
    step("push_then_pop_b", 0, 1, POP,  2, 32'h0000_0000, 0, 8'h00, 0, 0);
`ifdef ACC_ADD_EN
    step("add_load_f0",     0, 1, LOAD, 0, 32'h0000_00F0, 0, 8'hF0, 0, 0);
    step("add_wrap",        0, 1, LOAD, 0, 32'h0000_0020, 1, 8'h10, 0, 0);
    step("add_push",        0, 1, PUSH, 0, 32'h0000_0001, 1, 8'h11, 1, 0);
    step("add_pop_ignored", 0, 1, POP,  0, 32'h0000_0050, 1, 8'h10, 0, 0);
    step("add_off_load",    0, 1, LOAD, 0, 32'h0000_0007, 0, 8'h07, 0, 0);
`endif
    step("final_hold",      0, 0, HOLD, 0, 32'h0000_0000, 0, q.size() > 0 ? q[$].acc : 8'h00,
         q.size() > 0 ? q[$].depth : 3'd0, q.size() > 0 ? q[$].err : 1'b0);
    repeat (3) @(negedge CLK);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
